// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// program-load port, and the IF/ID pipeline register handed to decode.
module riscv_fetch_stage #(
    parameter int                   REG_WIDTH = 32,
    parameter int                   NUM_INST  = 128,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]          NOP_INSTR = 32'h00000013
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        prog_we,
    input  logic [$clog2(NUM_INST)-1:0] prog_addr,
    input  logic [31:0]                 prog_data,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [REG_WIDTH-1:0]        redirect_pc,
    output logic                        if_id_valid,
    output logic [REG_WIDTH-1:0]        if_id_pc,
    output logic [REG_WIDTH-1:0]        if_id_pc_plus4,
    output logic [31:0]                 if_id_instr
);

    localparam int IDX_W = $clog2(NUM_INST);

    // Declaration-time zero fill so unloaded words never read as X.
    logic [31:0]          mem_r [NUM_INST] = '{default: 32'h00000000};
    logic [REG_WIDTH-1:0] pc_r;

    logic [IDX_W-1:0]     fetch_idx_s;
    logic                 in_range_s;
    logic [31:0]          fetch_instr_s;
    logic [REG_WIDTH-1:0] pc_plus4_s;

    logic [REG_WIDTH-1:0] pc_next_s;
    logic                 valid_next_s;
    logic [REG_WIDTH-1:0] if_pc_next_s;
    logic [REG_WIDTH-1:0] if_pc4_next_s;
    logic [31:0]          instr_next_s;

    assign fetch_idx_s = pc_r[2 +: IDX_W];
    assign in_range_s  = ({2'b00, pc_r[REG_WIDTH-1:2]} < REG_WIDTH'(NUM_INST));
    assign pc_plus4_s  = pc_r + REG_WIDTH'(4);

    // Combinational instruction read from the current PC.
    always_comb begin
        fetch_instr_s = NOP_INSTR;
        if (in_range_s) begin
            fetch_instr_s = mem_r[fetch_idx_s];
        end else begin
            fetch_instr_s = NOP_INSTR;
        end
    end

    // Next PC / IF/ID selection: program load > redirect > stall > sequential fetch.
    always_comb begin
        pc_next_s     = pc_r;
        valid_next_s  = if_id_valid;
        if_pc_next_s  = if_id_pc;
        if_pc4_next_s = if_id_pc_plus4;
        instr_next_s  = if_id_instr;
        if (prog_we) begin
            pc_next_s = pc_r;
        end else if (redirect) begin
            // Squash the wrong-path slot; PC fields deliberately keep their old values.
            pc_next_s    = {redirect_pc[REG_WIDTH-1:2], 2'b00};
            valid_next_s = 1'b0;
            instr_next_s = NOP_INSTR;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s     = pc_plus4_s;
            valid_next_s  = in_range_s;
            if_pc_next_s  = pc_r;
            if_pc4_next_s = pc_plus4_s;
            instr_next_s  = fetch_instr_s;
        end
    end

    // PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r           <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_instr    <= NOP_INSTR;
        end else begin
            pc_r           <= pc_next_s;
            if_id_valid    <= valid_next_s;
            if_id_pc       <= if_pc_next_s;
            if_id_pc_plus4 <= if_pc4_next_s;
            if_id_instr    <= instr_next_s;
        end
    end

    // Program-load write port; contents survive reset but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (prog_we && !rst) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

endmodule
